// File: rtl/multicycle_ctrl.sv
// Multicycle RV32-subset control FSM: sequences fetch/decode/execute/memory/writeback
// and produces datapath strobes, a sticky illegal-opcode flag and a retire counter.
module multicycle_ctrl #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] instr,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic [1:0]       pc_src,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic [2:0]       imm_sel,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [Width-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC     = 4'd2,
        S_WB_ALU   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_WB_MEM   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t           state_reg;
    state_t           state_next;
    logic [Width-1:0] retired_reg;
    logic             illegal_reg;
    logic             retire;

    logic             mem_req_dec;
    logic             mem_we_dec;
    logic             ir_we_dec;
    logic             pc_we_dec;
    logic             reg_we_dec;

    logic [6:0]       opcode;
    logic             unused_instr_bits;

    // The IR is stable from DECODE until the next fetch, so the opcode can steer
    // the operand selects of the states that follow it.
    assign opcode            = instr[6:0];
    assign unused_instr_bits = ^instr[Width-1:7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            retired_reg <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (retire) begin
                retired_reg <= retired_reg + Width'(1);
            end
            if (state_next == S_TRAP) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        mem_req_dec = 1'b0;
        mem_we_dec  = 1'b0;
        ir_we_dec   = 1'b0;
        pc_we_dec   = 1'b0;
        reg_we_dec  = 1'b0;
        i_or_d      = 1'b0;
        pc_src      = 2'b00;
        alu_src_b   = 1'b0;
        alu_op      = 2'b00;
        wb_sel      = 2'b00;
        imm_sel     = 3'd0;
        retire      = 1'b0;

        case (state_reg)
            S_FETCH: begin
                mem_req_dec = 1'b1;
                if (mem_ready) begin
                    ir_we_dec  = 1'b1;
                    pc_we_dec  = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_REG, OP_IMM:    state_next = S_EXEC;
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_EXEC: begin
                alu_op = 2'b01;
                if (opcode == OP_IMM) begin
                    alu_src_b = 1'b1;
                    imm_sel   = 3'd1;
                end
                state_next = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_we_dec = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_b = 1'b1;
                if (opcode == OP_STORE) begin
                    imm_sel    = 3'd2;
                    state_next = S_MEM_WR;
                end else begin
                    imm_sel    = 3'd1;
                    state_next = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                mem_req_dec = 1'b1;
                i_or_d      = 1'b1;
                if (mem_ready) begin
                    state_next = S_WB_MEM;
                end
            end
            S_WB_MEM: begin
                reg_we_dec = 1'b1;
                wb_sel     = 2'b01;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_dec = 1'b1;
                mem_we_dec  = 1'b1;
                i_or_d      = 1'b1;
                imm_sel     = 3'd2;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                imm_sel    = 3'd3;
                pc_src     = 2'b01;
                pc_we_dec  = br_taken;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                imm_sel    = 3'd4;
                reg_we_dec = 1'b1;
                wb_sel     = 2'b10;
                pc_we_dec  = 1'b1;
                pc_src     = 2'b01;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JALR: begin
                imm_sel    = 3'd1;
                alu_src_b  = 1'b1;
                reg_we_dec = 1'b1;
                wb_sel     = 2'b10;
                pc_we_dec  = 1'b1;
                pc_src     = 2'b10;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_TRAP;
            end
        endcase
    end

    // Strobes are gated by rst_n so nothing fires while reset is held, whatever the decode says.
    assign mem_req = mem_req_dec & rst_n;
    assign mem_we  = mem_we_dec  & rst_n;
    assign ir_we   = ir_we_dec   & rst_n;
    assign pc_we   = pc_we_dec   & rst_n;
    assign reg_we  = reg_we_dec  & rst_n;

    assign state   = state_reg;
    assign illegal = illegal_reg;
    assign retired = retired_reg;

endmodule
